// File: rtl/eeprom_reader.sv
// ----------------------------------------------------------------------------
// eeprom_reader
//   Sequential reader for the board's parallel 8Kx8 EEPROM. It waits a
//   power-up delay after reset, then waits for a start pulse. For each byte it
//   drives the address and raises OE for a fixed access time. It samples the
//   data bus while OE is still high, then presents the byte on a valid/ready
//   handshake. WR is never asserted.
//
// Build option:
//   EEPROM_READER_CHECKSUM_EN  When defined, checksum accumulates the bytes
//                              the consumer accepts (8-bit wrap). When
//                              undefined, checksum is tied to 8'h00. The port
//                              list is the same in both builds.
//
// Parameters:
//   MEM_SIZE       bytes read per run (1..8192)
//   START_ADDR     first EEPROM address (13 bits)
//   SETTLE_COUNT   cycles OE is held high before data is sampled (>=1)
//   POWERUP_COUNT  cycles after reset release before start is accepted (>=1)
//
// Ports:
//   clk        in   system clock, posedge
//   reset      in   asynchronous active-low reset
//   start      in   1-cycle pulse, begins a run (accepted in IDLE/DONE only)
//   address    out  EEPROM address pins (13)
//   data       in   EEPROM data pins (8)
//   OE         out  output enable, active-high, high only in ACCESS
//   WR         out  write strobe, constant 0
//   out_data   out  byte read (8)
//   out_addr   out  EEPROM address of out_data (13)
//   out_valid  out  out_data/out_addr valid
//   out_ready  in   consumer accepts when out_valid && out_ready
//   busy       out  high in SETUP/ACCESS/PRESENT
//   done       out  high in DONE, held until next start
//   checksum   out  sum of accepted bytes mod 256 (see build option)
// ----------------------------------------------------------------------------
module eeprom_reader #(
  parameter int          MEM_SIZE      = 64,
  parameter logic [12:0] START_ADDR    = 13'd0,
  parameter int          SETTLE_COUNT  = 5000,
  parameter int          POWERUP_COUNT = 5000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [12:0] address,
  input  logic [7:0]  data,
  output logic        OE,
  output logic        WR,
  output logic [7:0]  out_data,
  output logic [12:0] out_addr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done,
  output logic [7:0]  checksum
);

  // One counter serves both the power-up delay and the access time, so it
  // is sized for the larger of the two.
  localparam int CNT_MAX = (POWERUP_COUNT > SETTLE_COUNT) ? POWERUP_COUNT : SETTLE_COUNT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

  localparam logic [CNT_W-1:0] PWR_LAST    = CNT_W'(POWERUP_COUNT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_COUNT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(MEM_SIZE - 1);

  typedef enum logic [2:0] {
    S_POWERUP,
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_PRESENT,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] counter;
  logic [IDX_W-1:0] idx;
  logic             accept;
  logic             run_start;
  logic             sample;

  // Next-state and decoded outputs
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    run_start = 1'b0;
    sample    = 1'b0;
    OE        = 1'b0;
    WR        = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_POWERUP: begin
        // start is deliberately not latched here
        if (counter == PWR_LAST) state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (start) begin
          run_start = 1'b1;
          state_nxt = S_SETUP;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          run_start = 1'b1;
          state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        busy      = 1'b1;
        state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        busy = 1'b1;
        OE   = 1'b1;
        if (counter == SETTLE_LAST) begin
          sample    = 1'b1;
          state_nxt = S_PRESENT;
        end
      end
      S_PRESENT: begin
        busy = 1'b1;
        if (out_valid && out_ready) begin
          accept    = 1'b1;
          state_nxt = (idx == IDX_LAST) ? S_DONE : S_SETUP;
        end
      end
      default: state_nxt = S_POWERUP;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_POWERUP;
    else        state <= state_nxt;
  end

  // Datapath registers. The reset clears everything, so an aborted run
  // never leaves a partial byte on the output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      counter   <= '0;
      idx       <= '0;
      address   <= 13'd0;
      out_data  <= 8'd0;
      out_addr  <= 13'd0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_POWERUP: counter <= (counter == PWR_LAST) ? '0 : counter + CNT_W'(1);
        S_SETUP:   counter <= '0;
        S_ACCESS:  counter <= counter + CNT_W'(1);
        default:   counter <= counter;
      endcase

      if (run_start) begin
        idx     <= '0;
        address <= START_ADDR;
      end

      // Data is captured on the edge that ends the last OE-high cycle, so
      // the EEPROM is still driving the bus.
      if (sample) begin
        out_data  <= data;
        out_addr  <= address;
        out_valid <= 1'b1;
      end

      if (accept) begin
        out_valid <= 1'b0;
        if (idx != IDX_LAST) begin
          idx     <= idx + IDX_W'(1);
          address <= address + 13'd1;  // 13-bit wrap: 8191 -> 0
        end
      end
    end
  end

`ifdef EEPROM_READER_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         checksum <= 8'h00;
    else if (run_start) checksum <= 8'h00;
    else if (accept)    checksum <= checksum + out_data;
  end
`else
  assign checksum = 8'h00;
`endif

endmodule

// File: tb/tb_eeprom_reader.sv
// ----------------------------------------------------------------------------
// tb_eeprom_reader
//   Directed bench for eeprom_reader. It uses MEM_SIZE=4, START_ADDR=1FFE,
//   SETTLE_COUNT=4 and POWERUP_COUNT=10. A four-location EEPROM model
//   answers at 1FFE, 1FFF, 0000 and 0001.
// ----------------------------------------------------------------------------
module tb_eeprom_reader;

  localparam int SETTLE = 4;

`ifdef EEPROM_READER_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [12:0] address;
  logic [7:0]  data;
  logic        OE;
  logic        WR;
  logic [7:0]  out_data;
  logic [12:0] out_addr;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;
  logic [7:0]  checksum;

  logic [7:0]  rom [4];
  int          total = 0;
  int          bad   = 0;

  eeprom_reader #(
    .MEM_SIZE     (4),
    .START_ADDR   (13'h1FFE),
    .SETTLE_COUNT (SETTLE),
    .POWERUP_COUNT(10)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .address  (address),
    .data     (data),
    .OE       (OE),
    .WR       (WR),
    .out_data (out_data),
    .out_addr (out_addr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy),
    .done     (done),
    .checksum (checksum)
  );

  always #5 clk = ~clk;

  always_comb begin
    data = 8'h5A;
    case (address)
      13'h1FFE: data = rom[0];
      13'h1FFF: data = rom[1];
      13'h0000: data = rom[2];
      13'h0001: data = rom[3];
      default:  data = 8'h5A;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered just after the edge that put the reader in SETUP for this byte.
  task automatic read_byte(input logic [12:0] ea, input logic [7:0] ed,
                           input int hold, input bit last, input bit poke);
    int oe_cnt;
    chk("setup_addr", 32'(address), 32'(ea));
    chk("setup_oe", 32'(OE), 32'd0);
    chk("setup_busy", 32'(busy), 32'd1);
    oe_cnt = 0;
    for (int i = 0; i < SETTLE; i++) begin
      if (poke && i == 1) start = 1'b1;
      tick();
      start = 1'b0;
      if (OE) oe_cnt++;
    end
    chk("oe_cycles", 32'(oe_cnt), 32'(SETTLE));
    tick();
    chk("present_valid", 32'(out_valid), 32'd1);
    chk("present_data", 32'(out_data), 32'(ed));
    chk("present_addr", 32'(out_addr), 32'(ea));
    chk("present_oe", 32'(OE), 32'd0);
    chk("wr_low", 32'(WR), 32'd0);
    if (hold > 0) begin
      out_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
        tick();
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'(out_data), 32'(ed));
        chk("hold_oe", 32'(OE), 32'd0);
        chk("hold_addr", 32'(address), 32'(ea));
      end
      out_ready = 1'b1;
    end
    tick();
    chk("accept_valid", 32'(out_valid), 32'd0);
    if (last) begin
      chk("done_set", 32'(done), 32'd1);
      chk("done_busy", 32'(busy), 32'd0);
    end else begin
      chk("next_busy", 32'(busy), 32'd1);
    end
  endtask

  initial begin
    rom[0] = 8'h11; rom[1] = 8'h22; rom[2] = 8'h33; rom[3] = 8'h44;
    start     = 1'b0;
    out_ready = 1'b1;
    reset     = 1'b1;
    #2 reset  = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_address", 32'(address), 32'd0);
    chk("rst_oe", 32'(OE), 32'd0);
    chk("rst_wr", 32'(WR), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_addr", 32'(out_addr), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_checksum", 32'(checksum), 32'd0);

    // Power-up: edges 1..10 after release are POWERUP
    reset = 1'b1;
    repeat (4) tick();
    start = 1'b1; tick(); start = 1'b0;          // sampled at edge 5
    chk("pwr_start5_busy", 32'(busy), 32'd0);
    repeat (3) tick();                           // through edge 8
    chk("pwr_busy8", 32'(busy), 32'd0);
    tick();                                      // edge 9
    start = 1'b1; tick(); start = 1'b0;          // sampled at edge 10, still POWERUP
    chk("pwr_start10_busy", 32'(busy), 32'd0);
    chk("pwr_idle_done", 32'(done), 32'd0);
    start = 1'b1; tick(); start = 1'b0;          // edge 11, in IDLE
    chk("start_busy", 32'(busy), 32'd1);

    // Run 1: wrap across 1FFF -> 0000, backpressure on byte 2
    read_byte(13'h1FFE, 8'h11, 0,  1'b0, 1'b0);
    read_byte(13'h1FFF, 8'h22, 20, 1'b0, 1'b0);
    read_byte(13'h0000, 8'h33, 0,  1'b0, 1'b0);
    read_byte(13'h0001, 8'h44, 0,  1'b1, 1'b0);
    chk("run1_checksum", 32'(checksum), CK_EN ? 32'hAA : 32'h00);
    tick(); tick();
    chk("done_held", 32'(done), 32'd1);
    chk("done_addr_hold", 32'(address), 32'h0001);
    chk("done_checksum_stable", 32'(checksum), CK_EN ? 32'hAA : 32'h00);

    // Run 2: restart from DONE, new bytes, start poked during ACCESS
    rom[0] = 8'hFF; rom[1] = 8'h02; rom[2] = 8'h10; rom[3] = 8'h01;
    start = 1'b1; tick(); start = 1'b0;
    chk("restart_done", 32'(done), 32'd0);
    chk("restart_addr", 32'(address), 32'h1FFE);
    chk("restart_checksum", 32'(checksum), 32'd0);
    read_byte(13'h1FFE, 8'hFF, 0, 1'b0, 1'b1);
    read_byte(13'h1FFF, 8'h02, 0, 1'b0, 1'b0);
    read_byte(13'h0000, 8'h10, 0, 1'b0, 1'b0);
    read_byte(13'h0001, 8'h01, 0, 1'b1, 1'b0);
    chk("run2_checksum", 32'(checksum), CK_EN ? 32'h12 : 32'h00);

    // Run 3: reset in the middle of ACCESS for byte 3
    start = 1'b1; tick(); start = 1'b0;
    read_byte(13'h1FFE, 8'hFF, 0, 1'b0, 1'b0);
    read_byte(13'h1FFF, 8'h02, 0, 1'b0, 1'b0);
    tick(); tick();
    chk("pre_rst_oe", 32'(OE), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("midrst_oe", 32'(OE), 32'd0);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_address", 32'(address), 32'd0);
    chk("midrst_out_addr", 32'(out_addr), 32'd0);
    chk("midrst_out_data", 32'(out_data), 32'd0);
    chk("midrst_checksum", 32'(checksum), 32'd0);
    tick();
    reset = 1'b1;
    repeat (2) tick();
    start = 1'b1; tick(); start = 1'b0;
    chk("post_rst_start_busy", 32'(busy), 32'd0);
    chk("post_rst_done", 32'(done), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
